// File: rtl/mux_8to1_pkg.sv
// Shared display constants for the dot-matrix pixel path.
package mux_8to1_pkg;

    localparam int   DISP_DATA_W = 8;
    localparam int   DISP_SEL_W  = 3;
    localparam logic PIXEL_OFF   = 1'b0;

endpackage

// File: rtl/mux_8to1.sv
// Registered 8:1 bit selector: drives dout[sel] as one serial pixel,
// one clock after sampling.
module mux_8to1
    import mux_8to1_pkg::*;
#(
    parameter int DATA_W = DISP_DATA_W,
    parameter int SEL_W  = DISP_SEL_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [SEL_W-1:0]  sel,
    input  logic [DATA_W-1:0] dout,
    output logic              pixel
);

    logic pixel_d;
    logic pixel_q;

    always_comb begin
        pixel_d = dout[sel];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pixel_q <= PIXEL_OFF;
        end else begin
            pixel_q <= pixel_d;
        end
    end

    assign pixel = pixel_q;

endmodule

// File: tb/tb_mux_8to1.sv
// Self-checking bench for mux_8to1: vector tables plus
// hand-written reset, latency and simultaneous-change sequences.
module tb_mux_8to1;

    typedef struct {
        logic [2:0] sel;
        logic [7:0] dout;
        logic       exp;
    } vec_t;

    logic       clk;
    logic       rst_n;
    logic [2:0] sel;
    logic [7:0] dout;
    logic       pixel;

    int   checks;
    int   errors;
    logic exp_q[$];

    mux_8to1 dut (
        .clk   (clk),
        .rst_n (rst_n),
        .sel   (sel),
        .dout  (dout),
        .pixel (pixel)
    );

    initial clk = 1'b0;
    always #50 clk = ~clk;

    task automatic chk(input string name, input logic act, input logic req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, req, $time);
        end
    endtask

    task automatic drive(input logic [2:0] s, input logic [7:0] d,
                         input logic e, input string name);
        logic req;
        @(negedge clk);
        sel  = s;
        dout = d;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s: scoreboard empty", name);
        end else begin
            req = exp_q.pop_front();
            chk(name, pixel, req);
        end
    endtask

    vec_t walk[8];
    vec_t scan[12];
    logic [2:0] scan_sel[12];
    logic       scan_exp[12];

    initial begin
        checks = 0;
        errors = 0;

        walk[0] = '{3'd0, 8'b1010_0101, 1'b1};
        walk[1] = '{3'd1, 8'b1010_0101, 1'b0};
        walk[2] = '{3'd2, 8'b1010_0101, 1'b1};
        walk[3] = '{3'd3, 8'b1010_0101, 1'b0};
        walk[4] = '{3'd4, 8'b1010_0101, 1'b0};
        walk[5] = '{3'd5, 8'b1010_0101, 1'b1};
        walk[6] = '{3'd6, 8'b1010_0101, 1'b0};
        walk[7] = '{3'd7, 8'b1010_0101, 1'b1};

        scan_sel = '{3'd0, 3'd1, 3'd4, 3'd0, 3'd7, 3'd2,
                     3'd2, 3'd5, 3'd0, 3'd3, 3'd6, 3'd5};
        scan_exp = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1,
                     1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        for (int i = 0; i < 12; i++) begin
            scan[i] = '{scan_sel[i], 8'h3C, scan_exp[i]};
        end

        // Reset asserted with no clock edge in between
        rst_n = 1'b1;
        sel   = 3'd7;
        dout  = 8'hFF;
        #5;
        rst_n = 1'b0;
        #1;
        chk("reset_async", pixel, 1'b0);
        @(posedge clk);
        #1;
        chk("reset_held_edge", pixel, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("reset_release_no_edge", pixel, 1'b0);
        exp_q.push_back(1'b1);
        @(posedge clk);
        #1;
        chk("reset_first_edge", pixel, exp_q.pop_front());

        for (int i = 0; i < 8; i++) begin
            drive(walk[i].sel, walk[i].dout, walk[i].exp,
                  $sformatf("walk_sel%0d", i));
        end

        for (int i = 0; i < 12; i++) begin
            for (int h = 0; h < 2; h++) begin
                drive(scan[i].sel, scan[i].dout, scan[i].exp,
                      $sformatf("scan_%0d_%0d", i, h));
            end
        end

        // Mid-cycle sel change must not reach pixel before the edge
        drive(3'd0, 8'h01, 1'b1, "latency_setup");
        @(negedge clk);
        sel = 3'd1;
        exp_q.push_back(1'b0);
        #10;
        chk("latency_hold", pixel, 1'b1);
        @(posedge clk);
        #1;
        chk("latency_edge", pixel, exp_q.pop_front());

        // Async reset between edges while pixel is high
        drive(3'd3, 8'h08, 1'b1, "midreset_setup");
        #20;
        rst_n = 1'b0;
        #1;
        chk("midreset_drop", pixel, 1'b0);
        @(posedge clk);
        #1;
        chk("midreset_hold", pixel, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        // Simultaneous sel/dout change keeps pixel high
        drive(3'd3, 8'h08, 1'b1, "simul_first");
        drive(3'd4, 8'h10, 1'b1, "simul_second");
        #40;
        chk("simul_mid", pixel, 1'b1);

        for (int i = 0; i < 20; i++) begin
            logic [2:0] s;
            logic [7:0] d;
            s = 3'($urandom_range(0, 7));
            d = 8'($urandom);
            drive(s, d, d[s], $sformatf("rand_%0d", i));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
